// File: rtl/conv_pkg.sv
// Shared types and defaults for the 3x3 convolution window sequencer and its datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    localparam int DIM_WIDTH_DEF    = 10;
    // The multiplier bank and adder_tree take their stage count from here so they track the valid pipe.
    localparam int PIPE_LATENCY_DEF = 3;
    localparam int CNT_WIDTH_DEF    = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Control/stream bundle between the window sequencer, pixel source, datapath and result writer.
// Latency: n/a (wires only).
// Backpressure: out_ready from the writer, pix_ready to the source; perf outputs under CONV_SEQ_PERF_CNT_EN.
interface conv_window_sequencer_if
    import conv_pkg::*;
#(
    parameter int DIM_WIDTH = DIM_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
    logic                 start;
    logic [DIM_WIDTH-1:0] cfg_width;
    logic [DIM_WIDTH-1:0] cfg_height;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 shift_en;
    logic                 window_valid;
    logic                 pipe_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 busy;
    logic                 done;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0]          perf_stall_cycles;
    logic [31:0]          perf_frame_cycles;

    modport master (
        input  start, cfg_width, cfg_height, pix_valid, out_ready,
        output pix_ready, shift_en, window_valid, pipe_en, out_valid, out_count, busy, done,
        output perf_stall_cycles, perf_frame_cycles
    );
    modport slave (
        output start, cfg_width, cfg_height, pix_valid, out_ready,
        input  pix_ready, shift_en, window_valid, pipe_en, out_valid, out_count, busy, done,
        input  perf_stall_cycles, perf_frame_cycles
    );
`else
    modport master (
        input  start, cfg_width, cfg_height, pix_valid, out_ready,
        output pix_ready, shift_en, window_valid, pipe_en, out_valid, out_count, busy, done
    );
    modport slave (
        output start, cfg_width, cfg_height, pix_valid, out_ready,
        input  pix_ready, shift_en, window_valid, pipe_en, out_valid, out_count, busy, done
    );
`endif
endinterface

// File: rtl/conv_valid_pipe.sv
// Valid-bit shadow of the multiply/add pipeline; top bit marks a registered adder_tree result.
// Latency: PIPE_LATENCY cycles from in_vld to out_vld when never stalled.
// Backpressure: holds every bit while pipe_en is low, exactly like the datapath registers.
module conv_valid_pipe
    import conv_pkg::*;
#(
    parameter int PIPE_LATENCY = PIPE_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pipe_en,
    input  logic in_vld,
    output logic out_vld,
    output logic inner_vld
);

    logic [PIPE_LATENCY-1:0] vld_q;

    generate
        if (PIPE_LATENCY == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else if (pipe_en) begin
                    vld_q <= in_vld;
                end
            end
            assign inner_vld = 1'b0;
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else if (pipe_en) begin
                    vld_q <= {vld_q[PIPE_LATENCY-2:0], in_vld};
                end
            end
            // Anything still travelling below the output stage.
            assign inner_vld = |vld_q[PIPE_LATENCY-2:0];
        end
    endgenerate

    assign out_vld = vld_q[PIPE_LATENCY-1];

endmodule

// File: rtl/conv_window_sequencer.sv
// 3x3 stride-1 window sequencer: counts raster pixels, flags complete windows, tracks them to the output.
// Latency: window_valid in the accept cycle, out_valid PIPE_LATENCY enabled cycles later; done one cycle after last output.
// Backpressure: out_valid && !out_ready drops pipe_en and pix_ready in the same cycle. CONV_SEQ_PERF_CNT_EN adds perf counters.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int DIM_WIDTH    = DIM_WIDTH_DEF,
    parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    conv_window_sequencer_if.master  sif
);

    seq_state_t           state;
    logic [DIM_WIDTH-1:0] w_m1, h_m1, row, col;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 done_q;
    logic                 out_vld, inner_vld;
    logic                 pipe_en, accept, start_ok, out_hs, win, drain_empty, busy;

    assign busy        = (state != IDLE);
    assign pipe_en     = !(out_vld && !sif.out_ready);
    assign accept      = sif.pix_valid && (state == RUN) && pipe_en;
    // A start coinciding with done is dropped so back-to-back frames see one idle cycle.
    assign start_ok    = sif.start && (state == IDLE) && !done_q;
    assign out_hs      = out_vld && sif.out_ready;
    assign win         = accept && (row >= DIM_WIDTH'(2)) && (col >= DIM_WIDTH'(2));
    assign drain_empty = !inner_vld && (!out_vld || sif.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            w_m1      <= '0;
            h_m1      <= '0;
            row       <= '0;
            col       <= '0;
            out_count <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_hs) begin
                out_count <= out_count + CNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        w_m1      <= sif.cfg_width - DIM_WIDTH'(1);
                        h_m1      <= sif.cfg_height - DIM_WIDTH'(1);
                        row       <= '0;
                        col       <= '0;
                        out_count <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col == w_m1) begin
                            col <= '0;
                            if (row == h_m1) begin
                                state <= DRAIN;
                            end else begin
                                row <= row + DIM_WIDTH'(1);
                            end
                        end else begin
                            col <= col + DIM_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    conv_valid_pipe #(
        .PIPE_LATENCY(PIPE_LATENCY)
    ) u_valid_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_en   (pipe_en),
        .in_vld    (win),
        .out_vld   (out_vld),
        .inner_vld (inner_vld)
    );

`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_frame_q <= '0;
        end else if (start_ok) begin
            perf_stall_q <= '0;
            perf_frame_q <= '0;
        end else if (busy) begin
            if (perf_frame_q != '1) perf_frame_q <= perf_frame_q + 32'd1;
            if (!pipe_en && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign sif.perf_stall_cycles = perf_stall_q;
    assign sif.perf_frame_cycles = perf_frame_q;
`endif

    assign sif.pix_ready    = (state == RUN) && pipe_en;
    assign sif.shift_en     = accept;
    assign sif.window_valid = win;
    assign sif.pipe_en      = pipe_en;
    assign sif.out_valid    = out_vld;
    assign sif.out_count    = out_count;
    assign sif.busy         = busy;
    assign sif.done         = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer (PIPE_LATENCY=3); perf checks only under CONV_SEQ_PERF_CNT_EN.
module tb_conv_window_sequencer;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_window_sequencer_if #(.DIM_WIDTH(10), .CNT_WIDTH(20)) sif ();

    conv_window_sequencer #(
        .DIM_WIDTH(10), .PIPE_LATENCY(3), .CNT_WIDTH(20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.master)
    );

    int errors, checks;
    int cyc_n, n_acc, n_win, n_out, n_done, n_busy, n_stall, n_blocked;
    int first_win, first_out, last_hs, done_cyc, done_busy;
    int cur_w, cur_h;
    int win_idx[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc_n = 0; n_acc = 0; n_win = 0; n_out = 0; n_done = 0; n_busy = 0;
        n_stall = 0; n_blocked = 0; first_win = -1; first_out = -1; last_hs = -1;
        done_cyc = -1; done_busy = -1;
        win_idx.delete();
    endtask

    // Observes one cycle at the falling edge; bench tracks row/col from its own accept count.
    task automatic sample();
        logic acc;
        int r, c;
        acc = sif.pix_valid && sif.pix_ready;
        r = n_acc / cur_w;
        c = n_acc % cur_w;
        check("shift_en", 32'(sif.shift_en), 32'(acc));
        check("pipe_en", 32'(sif.pipe_en), 32'(!(sif.out_valid && !sif.out_ready)));
        check("window_valid", 32'(sif.window_valid), 32'(acc && r >= 2 && c >= 2));
        if (!sif.busy) check("idle_pix_ready", 32'(sif.pix_ready), 32'(0));
        if (sif.out_valid && !sif.out_ready) begin
            check("stall_pix_ready", 32'(sif.pix_ready), 32'(0));
            n_stall++;
        end
        if (sif.pix_valid && !sif.pix_ready && sif.busy && n_acc < cur_w * cur_h) n_blocked++;
        if (acc) begin
            if (sif.window_valid) begin
                win_idx.push_back(n_acc);
                if (first_win < 0) first_win = cyc_n;
                n_win++;
            end
            n_acc++;
        end
        if (sif.out_valid) begin
            check("out_count", 32'(sif.out_count), 32'(n_out));
            if (first_out < 0) first_out = cyc_n;
            if (sif.out_ready) begin
                n_out++;
                last_hs = cyc_n;
            end
        end
        if (sif.busy) n_busy++;
        if (sif.done) begin
            n_done++;
            done_cyc  = cyc_n;
            done_busy = int'(sif.busy);
        end
        cyc_n++;
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int w, input int h, input bit toggle, input int stall_len, input bit poke);
        int stall_left;
        bit stalled, ph, fin;
        clear_stats();
        cur_w = w; cur_h = h;
        sif.cfg_width = 10'(w); sif.cfg_height = 10'(h);
        sif.start = 1'b1; sif.pix_valid = 1'b0; sif.out_ready = 1'b1;
        cyc();
        stall_left = 0; stalled = 1'b0; ph = 1'b1; fin = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            sif.pix_valid = toggle ? ph : 1'b1;
            ph = !ph;
            if (!stalled && sif.out_valid && stall_len > 0) begin
                stalled = 1'b1;
                stall_left = stall_len;
            end
            sif.out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            sif.start = 1'b0;
            if (poke && k == 6) begin
                sif.start = 1'b1; sif.cfg_width = 10'd3; sif.cfg_height = 10'd3;
            end
            if (poke && sif.done) sif.start = 1'b1;
            cyc();
            fin = (n_done != 0);
        end
        check("frame_finished", 32'(fin), 32'(1));
        sif.start = 1'b0; sif.pix_valid = 1'b1; sif.out_ready = 1'b1;
        repeat (4) cyc();
        sif.pix_valid = 1'b0;
        check("busy_after_done", 32'(sif.busy), 32'(0));
        check("accepts", 32'(n_acc), 32'(w * h));
        check("windows", 32'(n_win), 32'((w - 2) * (h - 2)));
        check("outputs", 32'(n_out), 32'((w - 2) * (h - 2)));
        check("done_pulses", 32'(n_done), 32'(1));
        check("done_timing", 32'(done_cyc), 32'(last_hs + 1));
        check("busy_at_done", 32'(done_busy), 32'(0));
        check("pipe_latency", 32'(first_out - first_win), 32'(3));
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0;
        sif.start = 1'b0; sif.cfg_width = '0; sif.cfg_height = '0;
        sif.pix_valid = 1'b0; sif.out_ready = 1'b1;
        cur_w = 4; cur_h = 4;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_ready", 32'(sif.pix_ready), 32'(0));
        check("rst_out_valid", 32'(sif.out_valid), 32'(0));
        check("rst_out_count", 32'(sif.out_count), 32'(0));
        check("rst_busy", 32'(sif.busy), 32'(0));
        check("rst_done", 32'(sif.done), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4x4, free-flowing: windows at 0-based accepts 10,11,14,15; busy cycles 1..19.
        run_frame(4, 4, 1'b0, 0, 1'b0);
        check("w4_nwin", 32'(win_idx.size()), 32'(4));
        if (win_idx.size() == 4) begin
            check("w4_idx0", 32'(win_idx[0]), 32'(10));
            check("w4_idx1", 32'(win_idx[1]), 32'(11));
            check("w4_idx2", 32'(win_idx[2]), 32'(14));
            check("w4_idx3", 32'(win_idx[3]), 32'(15));
        end
        check("w4_busy_cycles", 32'(n_busy), 32'(19));
        check("w4_stalls", 32'(n_stall), 32'(0));

        // 5x3 with pix_valid toggling: windows only at row 2, cols 2..4.
        run_frame(5, 3, 1'b1, 0, 1'b0);
        check("w5_nwin", 32'(win_idx.size()), 32'(3));
        if (win_idx.size() == 3) begin
            check("w5_idx0", 32'(win_idx[0]), 32'(12));
            check("w5_idx2", 32'(win_idx[2]), 32'(14));
        end

        // 4x4 with out_ready low for 5 cycles at the first out_valid (inputs still pending).
        run_frame(4, 4, 1'b0, 5, 1'b0);
        check("stall_cycles", 32'(n_stall), 32'(5));
        check("stall_blocked_pixels", 32'(n_blocked), 32'(5));
        check("stall_busy_cycles", 32'(n_busy), 32'(24));
`ifdef CONV_SEQ_PERF_CNT_EN
        check("perf_stall", sif.perf_stall_cycles, 32'(5));
        check("perf_frame", sif.perf_frame_cycles, 32'(n_busy));
`endif

        // start pulsed mid-RUN with 3x3 config and again in the done cycle: both ignored.
        run_frame(4, 4, 1'b0, 0, 1'b1);
        check("poke_busy_cycles", 32'(n_busy), 32'(19));

        // Reset with counters at row 2, col 1 of a 6x6 frame.
        clear_stats();
        cur_w = 6; cur_h = 6;
        sif.cfg_width = 10'd6; sif.cfg_height = 10'd6;
        sif.start = 1'b1; sif.pix_valid = 1'b0; sif.out_ready = 1'b1;
        cyc();
        sif.start = 1'b0; sif.pix_valid = 1'b1;
        for (int k = 0; k < 100 && n_acc < 13; k++) cyc();
        check("mid_accepts", 32'(n_acc), 32'(13));
        rst_n = 1'b0;
        #1;
        check("mid_rst_pix_ready", 32'(sif.pix_ready), 32'(0));
        check("mid_rst_shift_en", 32'(sif.shift_en), 32'(0));
        check("mid_rst_window", 32'(sif.window_valid), 32'(0));
        check("mid_rst_out_valid", 32'(sif.out_valid), 32'(0));
        check("mid_rst_out_count", 32'(sif.out_count), 32'(0));
        check("mid_rst_busy", 32'(sif.busy), 32'(0));
        check("mid_rst_done", 32'(sif.done), 32'(0));
        repeat (2) cyc();
        check("mid_rst_no_done", 32'(n_done), 32'(0));
        rst_n = 1'b1;
        sif.pix_valid = 1'b0;
        cyc();
        run_frame(3, 3, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
